// File: rtl/dla_irq_ctrl_if.sv
// Avalon-MM CSR bus between the AFU register master and the DLA interrupt controller.
// Word-addressed, fixed one-cycle read latency, never stalls.
interface dla_irq_ctrl_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/dla_irq_ctrl.sv
// DLA interrupt controller: latches event pulses into RW1C status, counts them, and drives
// level IRQ lines that always drop for a cycle after a clear so the write mux sees a new edge.
module dla_irq_ctrl #(
  parameter int NUM_IRQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] evt,
  output logic [NUM_IRQ-1:0] irq,
  dla_irq_ctrl_if.slave      csr
);

  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_ENABLE = 4'd1;
  localparam logic [3:0] ADDR_FORCE  = 4'd2;
  localparam logic [3:0] ADDR_COUNT0 = 4'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_IRQ-1:0]   status;
  logic [NUM_IRQ-1:0]   enable;
  logic [NUM_IRQ-1:0]   clr_q;
  logic [CNT_WIDTH-1:0] cnt [NUM_IRQ];

  logic                 wr_status;
  logic                 wr_enable;
  logic                 wr_force;
  logic [NUM_IRQ-1:0]   wr_count;
  logic [NUM_IRQ-1:0]   w1c_hit;
  logic [NUM_IRQ-1:0]   force_hit;
  logic [31:0]          rd_mux;

  logic                 unused_wdata;
  assign unused_wdata = ^csr.writedata[31:NUM_IRQ];

  assign csr.waitrequest = 1'b0;

  always_comb begin
    wr_status = csr.write && (csr.address == ADDR_STATUS);
    wr_enable = csr.write && (csr.address == ADDR_ENABLE);
    wr_force  = csr.write && (csr.address == ADDR_FORCE);
    for (int i = 0; i < NUM_IRQ; i++) begin
      wr_count[i] = csr.write && (csr.address == ADDR_COUNT0 + 4'(i));
    end
    w1c_hit   = wr_status ? csr.writedata[NUM_IRQ-1:0] : '0;
    force_hit = wr_force  ? csr.writedata[NUM_IRQ-1:0] : '0;
  end

  // Sets (event or force) take priority over W1C so a coincident event is never dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= '0;
      enable <= '0;
      clr_q  <= '0;
    end else begin
      status <= (status & ~w1c_hit) | evt | force_hit;
      clr_q  <= w1c_hit;
      if (wr_enable) begin
        enable <= csr.writedata[NUM_IRQ-1:0];
      end
    end
  end

  // clr_q holds irq low for one cycle after any clear, guaranteeing a fresh rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= '0;
    end else begin
      irq <= status & enable & ~clr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (wr_count[i]) begin
          cnt[i] <= evt[i] ? CNT_ONE : '0;
        end else if (evt[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr.address)
      ADDR_STATUS: rd_mux[NUM_IRQ-1:0] = status;
      ADDR_ENABLE: rd_mux[NUM_IRQ-1:0] = enable;
      4'd4, 4'd5, 4'd6, 4'd7: rd_mux = 32'(cnt[csr.address[1:0]]);
      default: rd_mux = '0;
    endcase
  end

  // Read data is sampled from pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr.readdata      <= '0;
      csr.readdatavalid <= 1'b0;
    end else begin
      csr.readdatavalid <= csr.read;
      if (csr.read) begin
        csr.readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_dla_irq_ctrl.sv
// Testbench for dla_irq_ctrl: directed scenarios plus random traffic checked every cycle
// against an event-level reference model of status, enable, counters and irq rearm.
module tb_dla_irq_ctrl;

  localparam int CMAX = 65535;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] evt;
  logic [3:0] irq;

  dla_irq_ctrl_if csr_bus ();

  dla_irq_ctrl #(.NUM_IRQ(4), .CNT_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .evt     (evt),
    .irq     (irq),
    .csr     (csr_bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          cyc = 0;
  logic [3:0]  m_status;
  logic [3:0]  m_enable;
  int          m_cnt [4];
  int          last_clr [4];
  logic [3:0]  m_irq;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_status = '0;
    m_enable = '0;
    m_irq    = '0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]    = 0;
      last_clr[i] = -100;
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    if (a == 4'd0) return {28'd0, m_status};
    if (a == 4'd1) return {28'd0, m_enable};
    if (a >= 4'd4 && a <= 4'd7) return 32'(m_cnt[int'(a) - 4]);
    return 32'd0;
  endfunction

  // One clock edge of the spec's rules, evaluated on the state seen before the edge.
  task automatic modelEdge(input logic [3:0] e, input logic rd, input logic wr,
                           input logic [3:0] a, input logic [31:0] d);
    logic clr;
    logic setf;
    if (rd) m_rdata = modelRead(a);
    m_rvalid = rd;
    for (int i = 0; i < 4; i++) begin
      m_irq[i] = m_status[i] && m_enable[i] && (last_clr[i] != cyc - 1);
    end
    for (int i = 0; i < 4; i++) begin
      clr  = wr && (a == 4'd0) && d[i];
      setf = wr && (a == 4'd2) && d[i];
      if (clr) last_clr[i] = cyc;
      m_status[i] = (m_status[i] && !clr) || e[i] || setf;
      if (wr && (int'(a) == 4 + i)) m_cnt[i] = e[i] ? 1 : 0;
      else if (e[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
    end
    if (wr && a == 4'd1) m_enable = d[3:0];
    cyc++;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check outputs 1ns later.
  task automatic applyStimulus(input logic [3:0] e, input logic rd, input logic wr,
                               input logic [3:0] a, input logic [31:0] d);
    evt               = e;
    csr_bus.read      = rd;
    csr_bus.write     = wr;
    csr_bus.address   = a;
    csr_bus.writedata = d;
    @(posedge clk);
    modelEdge(e, rd, wr, a, d);
    #1;
    checkOutput("irq", 32'(irq), 32'(m_irq));
    checkOutput("rvalid", 32'(csr_bus.readdatavalid), 32'(m_rvalid));
    if (m_rvalid) checkOutput("rdata", csr_bus.readdata, m_rdata);
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a, input logic [31:0] exp);
    applyStimulus(4'd0, 1'b1, 1'b0, a, 32'd0);
    checkOutput(tag, csr_bus.readdata, exp);
  endtask

  task automatic resetDut();
    reset_n           = 1'b0;
    evt               = '0;
    csr_bus.read      = 1'b0;
    csr_bus.write     = 1'b0;
    csr_bus.address   = '0;
    csr_bus.writedata = '0;
    resetModel();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  re;
    logic [3:0]  ra;
    logic [31:0] rd;
    int          op;

    resetDut();
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_rvalid", 32'(csr_bus.readdatavalid), 32'd0);
    checkOutput("reset_rdata", csr_bus.readdata, 32'd0);
    checkOutput("waitrequest", 32'(csr_bus.waitrequest), 32'd0);

    $display("[TB] basic interrupt");
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd1, 32'hF);
    applyStimulus(4'b0100, 1'b0, 1'b0, 4'd0, 32'd0);
    checkOutput("basic_irq_e", 32'(irq), 32'd0);
    idle();
    checkOutput("basic_irq_e1", 32'(irq), 32'h4);
    readCheck("basic_status", 4'd0, 32'h4);
    readCheck("basic_cnt2", 4'd6, 32'd1);
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd0, 32'h4);
    checkOutput("basic_clr_c", 32'(irq), 32'h4);
    idle();
    checkOutput("basic_clr_c1", 32'(irq), 32'h0);
    readCheck("basic_status_clr", 4'd0, 32'h0);

    $display("[TB] coincident clear and event");
    applyStimulus(4'b0010, 1'b0, 1'b0, 4'd0, 32'd0);
    idle();
    checkOutput("coin_pre", 32'(irq), 32'h2);
    applyStimulus(4'b0010, 1'b0, 1'b1, 4'd0, 32'h2);
    checkOutput("coin_e", 32'(irq), 32'h2);
    idle();
    checkOutput("coin_e1_low", 32'(irq), 32'h0);
    idle();
    checkOutput("coin_e2_high", 32'(irq), 32'h2);
    readCheck("coin_status", 4'd0, 32'h2);

    $display("[TB] masking");
    resetDut();
    applyStimulus(4'b0001, 1'b0, 1'b0, 4'd0, 32'd0);
    idle();
    idle();
    checkOutput("mask_irq_off", 32'(irq), 32'h0);
    readCheck("mask_status", 4'd0, 32'h1);
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd1, 32'h1);
    checkOutput("mask_w", 32'(irq), 32'h0);
    idle();
    checkOutput("mask_w1", 32'(irq), 32'h1);

    $display("[TB] force and unmapped space");
    resetDut();
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd1, 32'hF);
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd2, 32'h9);
    checkOutput("force_f", 32'(irq), 32'h0);
    idle();
    checkOutput("force_f1", 32'(irq), 32'h9);
    readCheck("unmapped_3", 4'd3, 32'h0);
    readCheck("unmapped_f", 4'hF, 32'h0);
    readCheck("force_reads0", 4'd2, 32'h0);
    readCheck("enable_rd", 4'd1, 32'hF);

    $display("[TB] counter saturation");
    resetDut();
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(4'b1000, 1'b0, 1'b0, 4'd0, 32'd0);
    end
    readCheck("sat_cnt3", 4'd7, 32'hFFFF);
    applyStimulus(4'b1000, 1'b0, 1'b1, 4'd7, 32'd0);
    readCheck("sat_clear_evt", 4'd7, 32'd1);

    $display("[TB] random traffic");
    resetDut();
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd1, 32'($urandom));
    for (int i = 0; i < 600; i++) begin
      re = 4'($urandom) & 4'($urandom);
      op = $urandom_range(0, 3);
      ra = 4'($urandom);
      rd = $urandom;
      applyStimulus(re, op[0], op[1], ra, rd);
    end

    $display("[TB] async reset mid-operation");
    resetDut();
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd1, 32'hF);
    applyStimulus(4'd0, 1'b0, 1'b1, 4'd2, 32'hF);
    idle();
    checkOutput("areset_pre_irq", 32'(irq), 32'hF);
    applyStimulus(4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_irq", 32'(irq), 32'h0);
    checkOutput("areset_rvalid", 32'(csr_bus.readdatavalid), 32'h0);
    checkOutput("areset_rdata", csr_bus.readdata, 32'h0);
    csr_bus.read = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    readCheck("post_status", 4'd0, 32'h0);
    readCheck("post_enable", 4'd1, 32'h0);
    for (int i = 4; i < 8; i++) begin
      readCheck("post_cnt", 4'(i), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dla_irq_ctrl.md
# dla_irq_ctrl

Interrupt controller for the DLA AFU. It collects single-cycle completion and error event pulses from the DLA IP and latches them in a software-visible status register. It drives the four level IRQ lines consumed by the host-memory write-channel mux, which converts each rising edge into a PIM interrupt write. It also guarantees every new interrupt presents a fresh rising edge on its IRQ line, so no interrupt is lost when software clears a vector while a new event arrives.

## Interface
Parameters:
- NUM_IRQ, 4, number of event sources and IRQ vectors, mapped 1:1. Fixed at 4 to match the PIM vector count.
- CNT_WIDTH, 16, width of each per-vector saturating event counter (≤32).

Ports:
- clk  in  1  block clock; all logic is in this single domain.
- reset_n  in  1  asynchronous, active-low reset.
- evt  in  NUM_IRQ  event pulses from the DLA IP. Each cycle high on bit i is one event on vector i.
- irq  out  NUM_IRQ  registered level interrupt lines to the host-memory write mux.
- csr_address  in  4  Avalon-MM word address.
- csr_read  in  1  read strobe.
- csr_write  in  1  write strobe.
- csr_writedata  in  32  write data.
- csr_readdata  out  32  read data.
- csr_readdatavalid  out  1  read-data valid.
- csr_waitrequest  out  1  constant 0; the slave never stalls.

## Operation
- **Address map** (word addresses):
  - 0 STATUS: RW1C, bits[3:0].
  - 1 ENABLE: RW, bits[3:0].
  - 2 FORCE: write-1-sets STATUS, reads 0.
  - 4–7 EVT_COUNT[0..3]: read returns the count zero-extended; any write clears it.
  - Other addresses read 0; writes to them are ignored. Unused bits read 0.
- **STATUS update.** Per bit i: status_next = (status & ~w1c_hit) | evt[i] | force_hit.
  - Set wins over clear, so an event coinciding with a W1C leaves the bit set.
- **EVT_COUNT update.** Increments on each evt[i] cycle regardless of ENABLE, and saturates at 2^CNT_WIDTH−1.
  - Write and evt in the same cycle: the counter becomes 1.
  - At saturation, further events leave the value unchanged.
- **Rearm.** clr_q[i] is a registered flag set in the cycle after any W1C write with writedata[i]=1 to STATUS; it lasts one cycle.
- **IRQ output.** irq[i] <= status[i] & enable[i] & ~clr_q[i].
  - After every clear of bit i, irq[i] is therefore low for at least one cycle, giving the downstream edge detector a fresh rising edge if status re-sets.
- **ENABLE gating.** Clearing ENABLE[i] deasserts irq[i] without touching STATUS. Re-enabling with STATUS[i]=1 re-asserts irq[i], which the mux treats as a new interrupt.
- **Read/write collision.** A read and a write in the same cycle are both honoured. The read returns the pre-write value.
- **Reset** (async assert, sync deassert handled upstream):
  - status, enable, all counters, clr_q: 0.
  - irq: 0; csr_readdata: 0; csr_readdatavalid: 0.
  - Events during reset are discarded.

## Timing
- Event on evt[i] sampled at edge E → STATUS[i]=1 after E → irq[i]=1 after E+1, provided ENABLE[i]=1 and no clear is in progress. Latency is 2 cycles.
- W1C at edge E → STATUS[i]=0 after E → irq[i]=0 after E+1.
- W1C at edge E coinciding with evt[i] → STATUS[i] stays 1; irq[i]=0 for exactly the cycle after E+1, then 1 after E+2.
- ENABLE write at E → irq reflects the new mask after E+1.
- Read issued at edge E → csr_readdatavalid=1 with data for exactly one cycle after E. Read latency is fixed at 1; back-to-back reads are supported at full rate.
- A read of STATUS or EVT_COUNT captures the value before any update at the same edge.
- reset_n assertion mid-operation clears irq immediately (asynchronously). No partial state survives.

## Test plan
- **Basic interrupt.** Reset; ENABLE=0xF; pulse evt=0b0100 for one cycle → irq[2] rises 2 cycles later; STATUS reads 0x4; EVT_COUNT[2] reads 1. W1C 0x4 → irq[2]=0 after 2 cycles; STATUS reads 0.
- **Coincident clear and event.** With STATUS[1]=1 and irq[1]=1, issue W1C 0x2 in the same cycle as evt[1] → STATUS stays 0x2; irq[1] low for exactly 1 cycle, then high.
- **Masking.** ENABLE=0; pulse evt[0] → irq stays 0, STATUS=0x1. Write ENABLE=0x1 → irq[0]=1 two cycles after the write edge.
- **Counter saturation.** Hold evt[3] high for 65540 cycles → EVT_COUNT[3]=0xFFFF. Write the register and pulse evt[3] in the same cycle → count reads 1.
- **FORCE and unmapped space.** Write FORCE=0x9 with ENABLE=0xF → irq=0x9 two cycles later. Read address 3 and address 0xF → 0, each with readdatavalid one cycle later.
- **Async reset mid-operation.** Assert reset_n=0 while irq=0xF and a read is in flight → irq=0 and readdatavalid=0 immediately. After release, all registers read 0.
